// File: rtl/multiword_add_seq.sv
// Sequential multiword adder: one 4-bit slice time-multiplexed over NIBBLES cycles.
// Define MWADD_SUB_EN to add the sub port and two's-complement subtraction.
module multiword_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
`ifdef MWADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [3:0]      slice_a, slice_b, slice_s;
  logic            slice_co;
  logic [W-1:0]    b_eff_in;
  logic            cin_eff;

  // b_q stores the effective B operand so the datapath never sees sub
`ifdef MWADD_SUB_EN
  assign b_eff_in = sub ? ~b : b;
  assign cin_eff  = sub ? 1'b1 : cin;
`else
  assign b_eff_in = b;
  assign cin_eff  = cin;
`endif

  // The single shared 4-bit slice adder
  assign slice_a = a_q[{k_q, 2'b00} +: 4];
  assign slice_b = b_q[{k_q, 2'b00} +: 4];
  assign {slice_co, slice_s} = 5'(slice_a) + 5'(slice_b) + 5'(carry_q);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_eff_in;
          carry_d = cin_eff;
          k_d     = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[{k_q, 2'b00} +: 4] = slice_s;
        carry_d = slice_co;
        if (k_q == KW'(NIBBLES - 1)) begin
          k_d     = '0;
          cout_d  = slice_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_s[3] != a_q[W-1]);
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized self-checking bench for multiword_add_seq against an arithmetic model.
module tb_multiword_add_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;
  localparam int          MAXCYC  = 20;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int n_vec = 0;
  int n_err = 0;

  multiword_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef MWADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-word arithmetic reference
  function automatic void model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                input logic ci, input logic s,
                                output logic [W-1:0] es, output logic ec, output logic eo);
    logic [W-1:0] beff;
    logic [W:0]   full;
    logic         c0;
    beff = bb;
    c0   = ci;
`ifdef MWADD_SUB_EN
    if (s) begin
      beff = ~bb;
      c0   = 1'b1;
    end
`else
    if (s) c0 = ci;
`endif
    full = {1'b0, aa} + {1'b0, beff} + (W+1)'(c0);
    es   = full[W-1:0];
    ec   = full[W];
    eo   = (aa[W-1] == beff[W-1]) && (es[W-1] != aa[W-1]);
  endfunction

  // Called at the negedge of the first cycle after acceptance
  task automatic wait_done(input bit hold, output int cyc, output int nbusy);
    cyc   = 1;
    nbusy = 0;
    while (done !== 1'b1 && cyc <= MAXCYC) begin
      if (busy === 1'b1) nbusy++;
      if (hold) begin
        a = 16'hAAAA;
      end else begin
        start = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  // Entered at a negedge; leaves at the done negedge (hold) or one cycle later
  task automatic run_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic ci, input logic s, input bit hold);
    logic [W-1:0] es;
    logic         ec, eo;
    int           cyc, nb;
`ifdef MWADD_SUB_EN
    model(aa, bb, ci, s, es, ec, eo);
`else
    model(aa, bb, ci, 1'b0, es, ec, eo);
`endif
    start = 1'b1;
    a     = aa;
    b     = bb;
    cin   = ci;
    sub   = s;
    @(negedge clk);
    if (!hold) start = 1'b0;
    wait_done(hold, cyc, nb);
    check({tag, "_latency"}, 32'(cyc), 32'(NIBBLES + 1));
    check({tag, "_busycyc"}, 32'(nb), 32'(NIBBLES));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    if (!hold) begin
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      @(negedge clk);
      check({tag, "_done_drop"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_sum_hold"}, 32'(sum), 32'(es));
    end
  endtask

  initial begin
    int           pulses;
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Abort on the second RUN cycle; ovf is 1 from the previous op
    start = 1'b1;
    a     = 16'h5A5A;
    b     = 16'h1111;
    cin   = 1'b0;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);

`ifdef MWADD_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
`endif

    // Back-to-back with start held; a changes to AAAA during the first RUN
    run_op("b2b_1", 16'h1357, 16'h2468, 1'b1, 1'b0, 1'b1);
    run_op("b2b_2", 16'hAAAA, 16'h2468, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 0) ra = {1'b0, {(W-1){1'b1}}};
      run_op("rand", ra, rb, rc, rs, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
